// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types, ROM geometry defaults and round-robin pick helper
package rom_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Widest requester vector the pick helper supports.
  localparam int MAXREQ    = 8;
  localparam int ROM_DEPTH = 256;
  localparam int ROM_ADDRW = $clog2(ROM_DEPTH);

  // One-hot winner: first set bit of req searching upward from last+1, wrapping at n.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                input logic [2:0]        last,
                                                input int                n);
    logic [MAXREQ-1:0] win;
    logic              found;
    logic [2:0]        idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAXREQ; k++) begin
      idx = 3'((int'(last) + k) % n);
      if (k <= n && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over NREQ requesters
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant_oh,
  output logic [LW-1:0]   grant_idx,
  output logic            any
);

  // Winner in one-hot and encoded form; the encoded index feeds last_grant.
  always_comb begin
    grant_oh  = NREQ'(rr_pick(MAXREQ'(req), 3'(last), NREQ));
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) grant_idx = LW'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst reader sharing one async ROM
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = ROM_DEPTH,
  parameter  int LENW  = 4,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int LW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ*LENW-1:0]  req_len,
  output logic [NREQ-1:0]       req_ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data
);

  arb_state_t       state;
  logic [LW-1:0]    last_grant;
  logic [LW-1:0]    grant;
  logic [ADDRW-1:0] cur_addr;
  logic [LENW-1:0]  remain;
  logic [NREQ-1:0]  win_oh;
  logic [LW-1:0]    win_idx;
  logic             win_any;
  logic [ADDRW-1:0] sel_addr;
  logic [LENW-1:0]  sel_len;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req),
    .last      (last_grant),
    .grant_oh  (win_oh),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // The ROM address comes straight from a register so the ROM sees a clean path.
  assign rom_addr = cur_addr;

  // Pull the winner's start address and length out of the packed buses.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        sel_addr = req_addr[i*ADDRW +: ADDRW];
        sel_len  = req_len[i*LENW +: LENW];
      end
    end
  end

  // Arbitrate in IDLE, then stream remain+1 words from the ROM in BURST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LW'(NREQ - 1);
      grant      <= '0;
      cur_addr   <= '0;
      remain     <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= '0;
          rsp_last  <= 1'b0;
          if (win_any) begin
            req_ack    <= win_oh;
            cur_addr   <= sel_addr;
            remain     <= sel_len;
            grant      <= win_idx;
            last_grant <= win_idx;
            busy       <= 1'b1;
            state      <= BURST;
          end else begin
            req_ack <= '0;
          end
        end
        BURST: begin
          req_ack   <= '0;
          rsp_data  <= rom_data;
          rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << grant;
          rsp_last  <= (remain == '0);
          cur_addr  <= cur_addr + ADDRW'(1);
          remain    <= remain - LENW'(1);
          if (remain == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - scoreboard bench for rom_burst_arbiter
module tb_rom_burst_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        busy;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;

  logic [7:0]  rom_mem [256];

  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    logic       l;
    logic [7:0] na;
  } rsp_t;

  rsp_t       rsp_q [$];
  logic [3:0] ack_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  rom_burst_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ack   (req_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  initial begin
    for (int a = 0; a < 256; a++) rom_mem[a] = 8'(a) ^ 8'h5A;
  end
  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // nwords < len+1 models a burst cut short by reset.
  task automatic push_burst(input int idx, input logic [7:0] addr, input int len, input int nwords);
    rsp_t e;
    ack_q.push_back(4'b0001 << idx);
    for (int k = 0; k < nwords; k++) begin
      e.v  = 4'b0001 << idx;
      e.d  = 8'(int'(addr) + k) ^ 8'h5A;
      e.l  = (k == len);
      e.na = 8'(int'(addr) + k + 1);
      rsp_q.push_back(e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic [3:0] got);
    got = '0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (req_ack != '0) begin
        got = req_ack;
        break;
      end
    end
    if (got == '0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got none expected an ack");
    end
  endtask

  task automatic wait_idle;
    int c;
    c = 0;
    while (busy && c < 60) begin
      tick();
      c++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy still 1 expected 0");
    end
    tick();
    tick();
  endtask

  // Monitor: sample on the falling edge and compare against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_ack != '0) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 32'(req_ack), 32'h0);
        end else begin
          check("ack_onehot", 32'(req_ack), 32'(ack_q.pop_front()));
        end
      end
      if (rsp_valid != '0) begin
        check("valid_single_bit", 32'($countones(rsp_valid)), 32'd1);
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(e.v));
          check("rsp_data", 32'(rsp_data), 32'(e.d));
          check("rsp_last", 32'(rsp_last), 32'(e.l));
          check("busy_with_rsp", 32'(busy), 32'(!e.l));
          check("rom_addr_next", 32'(rom_addr), 32'(e.na));
        end
      end else begin
        if (rsp_last) check("last_without_valid", 32'(rsp_last), 32'h0);
      end
    end
  end

  initial begin
    logic [3:0] got;
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    tick();
    tick();
    check("reset_req_ack", 32'(req_ack), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", 32'(rsp_data), 32'h0);
    check("reset_rsp_last", 32'(rsp_last), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    tick();

    // Single burst from requester 0: 4A,4B,48,49.
    req_addr[0*8 +: 8] = 8'h10;
    req_len[0*4 +: 4]  = 4'd3;
    push_burst(0, 8'h10, 3, 4);
    req[0] = 1'b1;
    wait_ack(got);
    req[0] = 1'b0;
    wait_idle();

    // Address wrap on requester 3: A4,A5,5A,5B. Leaves last_grant at 3.
    req_addr[3*8 +: 8] = 8'hFE;
    req_len[3*4 +: 4]  = 4'd3;
    push_burst(3, 8'hFE, 3, 4);
    req[3] = 1'b1;
    wait_ack(got);
    req[3] = 1'b0;
    wait_idle();

    // All four continuously, single-word bursts: 0,1,2,3,0.
    req_addr = {8'h70, 8'h60, 8'h50, 8'h40};
    req_len  = '0;
    push_burst(0, 8'h40, 0, 1);
    push_burst(1, 8'h50, 0, 1);
    push_burst(2, 8'h60, 0, 1);
    push_burst(3, 8'h70, 0, 1);
    push_burst(0, 8'h40, 0, 1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) wait_ack(got);
    req = '0;
    wait_idle();

    // Longest burst; inputs disturbed mid-burst must not matter.
    req_addr[0*8 +: 8] = 8'h80;
    req_len[0*4 +: 4]  = 4'hF;
    push_burst(0, 8'h80, 15, 16);
    req[0] = 1'b1;
    wait_ack(got);
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    req_addr[0*8 +: 8] = 8'h00;
    req_len[0*4 +: 4]  = 4'h0;
    wait_idle();

    // Fairness: 2 holds req, 1 and 3 re-request after every ack.
    req_addr = {8'hC0, 8'hB0, 8'hA0, 8'h00};
    req_len  = '0;
    for (int r = 0; r < 2; r++) begin
      push_burst(1, 8'hA0, 0, 1);
      push_burst(2, 8'hB0, 0, 1);
      push_burst(3, 8'hC0, 0, 1);
    end
    req = 4'b1110;
    for (int g = 0; g < 6; g++) begin
      wait_ack(got);
      if (g == 5) begin
        req = '0;
      end else begin
        req = (req & ~got) | 4'b0100;
        tick();
        req = req | 4'b1010;
      end
    end
    wait_idle();

    // Reset during the third word of an 8-word burst.
    req_addr[2*8 +: 8] = 8'h20;
    req_len[2*4 +: 4]  = 4'd7;
    push_burst(2, 8'h20, 7, 2);
    req[2] = 1'b1;
    wait_ack(got);
    req[2] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("midrst_rsp_data", 32'(rsp_data), 32'h0);
    check("midrst_rsp_last", 32'(rsp_last), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_rom_addr", 32'(rom_addr), 32'h0);
    check("midrst_req_ack", 32'(req_ack), 32'h0);
    req_addr[3*8 +: 8] = 8'h30;
    req_len[3*4 +: 4]  = 4'd0;
    push_burst(3, 8'h30, 0, 1);
    req = 4'b1000;
    tick();
    tick();
    rst = 1'b0;
    wait_ack(got);
    req = '0;
    wait_idle();

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one asynchronous ROM (combinational addr->data) between NREQ requesters, e.g. frog sprite, vehicle sprites and background tiles.
- Each requester asks for a burst of consecutive words.
- Arbitration is round-robin; a grant is held for the whole burst.
- Read data is registered and returned on a shared bus, tagged by a one-hot valid.
- Sits between the sprite/tile engines and the ROM instance, in the pixel clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, ROM data width.
- DEPTH, 256, ROM depth in words; ADDRW = $clog2(DEPTH), derived localparam.
- LENW, 4, burst-length field width; burst = req_len+1 words (1..2^LENW).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req  in  NREQ  per-requester request level; held until the matching req_ack.
- req_addr  in  NREQ*ADDRW  packed start addresses, slice i belongs to requester i.
- req_len  in  NREQ*LENW  packed burst lengths minus one.
- req_ack  out  NREQ  one-hot pulse: request accepted, inputs latched.
- rsp_valid  out  NREQ  one-hot: rsp_data belongs to requester i this cycle.
- rsp_data  out  WIDTH  registered ROM word.
- rsp_last  out  1  final word of the current burst; qualifies rsp_valid.
- busy  out  1  burst in progress.
- rom_addr  out  ADDRW  address to the async ROM.
- rom_data  in  WIDTH  data from the async ROM, valid in the same cycle as rom_addr.

Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Reset values (async assert): req_ack=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, rom_addr=0, state=IDLE, last_grant=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE and BURST.
- IDLE, no req set: stay in IDLE; rom_addr holds its last value.
- IDLE, any req set, winner selection: winner = first set bit searching from last_grant+1 upward with wrap.
- IDLE, any req set, at the clock edge:
  - req_ack[winner]=1 for exactly one cycle.
  - Latch cur_addr=req_addr[winner], remain=req_len[winner], grant=winner.
  - Set last_grant=winner, busy=1, go to BURST.
- BURST, combinational path: rom_addr = cur_addr, driven from a register.
- BURST, each clock edge:
  - rsp_data <= rom_data, rsp_valid <= onehot(grant), rsp_last <= (remain==0).
  - cur_addr <= cur_addr+1, modulo DEPTH; wraps from DEPTH-1 to 0 with no error.
  - remain <= remain-1.
  - When remain==0: go to IDLE, busy <= 0.
- Latency:
  - req high before edge 0 -> req_ack high after edge 0.
  - First rsp_valid high after edge 1.
  - Burst of L+1 words occupies rsp_valid for L+1 consecutive cycles.
  - Next arbitration edge follows the last data edge, giving one dead cycle between bursts.
  - Back-to-back throughput is (L+1)/(L+2).
- rsp_valid is never asserted in IDLE-only cycles; at most one rsp_valid bit is set at any time.
- Changes to req, req_addr or req_len during a burst are ignored; inputs are sampled only in IDLE.
- A requester that drops req before its ack is not served; there is no queue.
- A requester that keeps req high after its ack is treated as a new request and competes again. Requesters must deassert in the ack cycle.
- Simultaneous requests: the round-robin order above applies strictly. With all requesters asserted continuously, grants go 0,1,2,3,0,...
- Reset mid-burst: everything returns to reset values immediately, the burst is abandoned, and no rsp_last is issued.
- Widths: the cur_addr increment is ADDRW bits and the remain decrement is LENW bits; no saturation is needed.

Decomposition:
- Package rom_arb_pkg holds:
  - typedef enum logic {IDLE, BURST} arb_state_t;
  - the function rr_pick(req, last) that returns the one-hot winner;
  - the helper localparam for ADDRW.
- One sub-module is natural: rr_arbiter (combinational round-robin pick over NREQ bits given last_grant). It can be reused by later sprite DMA blocks.
- The bench instantiates rom_burst_arbiter together with the existing async ROM, loaded with a known hex file where word[a] = a ^ 8'h5A.

Test Plan:
1. Single request: req=4'b0001, addr=8'h10, len=3 -> req_ack[0] one cycle; rsp_valid[0] for 4 cycles with data 4A,4B,48,49; rsp_last on the 4th word; busy falls after it.
2. All four requesting continuously, len=0 -> grants in order 0,1,2,3,0. Each grant gives one rsp cycle followed by one arbitration cycle; there is never more than one rsp_valid bit set.
3. Wrap-around: addr=8'hFE, len=3 -> rom_addr sequence FE,FF,00,01; data A4,A5,5A,5B.
4. Maximum length: len=4'hF -> exactly 16 rsp_valid cycles. req_addr/req_len changed mid-burst have no effect.
5. Fairness: requester 2 holds req permanently while 1 and 3 re-request after every ack -> order is 1,2,3,1,2,3. Requester 2 is never starved.
6. Async reset asserted during the 3rd word of a len=7 burst -> all outputs 0 in the same cycle, no rsp_last. After release, a pending req=4'b1000 is granted first (last_grant=3 -> search starts at 0, only bit 3 set).
